fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 19 +
 rtl/inst_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 64;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 64'h0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - small instruction buffer with push, pop, clear and occupancy count
module inst_fifo #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clear,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Guard against overflow/underflow so a stray request can never corrupt state.
  always_comb begin
    do_push = push && (count != CNT_W'(DEPTH));
    do_pop  = pop && (count != '0);
  end

  assign head_data = mem[rd_ptr];

  // Storage, pointers and count; clear empties the buffer and wins over push/pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetcher with redirect and 2-entry buffer
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  // A redirect clears the buffer, so a same-cycle pop has nothing left to remove.
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  // Next-state and request/push decode; redirect suppresses both requests and pushes.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    push           = 1'b0;
    case (state)
      FETCH: begin
        imem_req_valid = reset_n && !redirect_valid &&
                         (count <= CNT_W'(BUF_DEPTH - 1));
        if (imem_req_valid && imem_req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          push      = !redirect_valid;
          state_nxt = FETCH;
        end else if (redirect_valid) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (imem_resp_valid) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // State register; reset abandons any request still in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Fetch PC: redirect target has priority, otherwise advance only on an accepted response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= align_pc(redirect_pc);
    end else if (push) begin
      fetch_pc <= fetch_pc + ADDR_W'(4);
    end
  end

  inst_fifo #(
    .DATA_W (ADDR_W + INST_W),
    .DEPTH  (BUF_DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({fetch_pc, imem_rdata}),
    .pop       (pop),
    .clear     (redirect_valid),
    .head_data ({inst_pc, inst}),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a delay-configurable memory model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  int          mem_delay = 1;
  logic        pend = 1'b0;
  logic [63:0] pend_addr = 64'h0;
  int          cnt = 0;
  logic        m_rst, m_acc, m_fire;
  logic [63:0] m_addr;

  fetch_unit #(
    .RESET_PC  (64'h0),
    .BUF_DEPTH (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_rdata      (imem_rdata),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory contents: upper half a fixed tag, lower half the address low bits.
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory model: sample the handshake at negedge, update response just after posedge.
  initial forever begin
    @(negedge clk);
    m_rst  = !reset_n;
    m_acc  = imem_req_valid && imem_req_ready;
    m_addr = imem_addr;
    m_fire = imem_resp_valid;
    @(posedge clk);
    #1;
    if (m_rst) begin
      pend = 1'b0;
    end else begin
      if (m_fire) pend = 1'b0;
      else if (pend && cnt > 0) cnt--;
      if (m_acc) begin
        pend      = 1'b1;
        cnt       = mem_delay - 1;
        pend_addr = m_addr;
      end
    end
    imem_resp_valid = pend && (cnt == 0);
    imem_rdata      = imem_resp_valid ? word_of(pend_addr) : 32'h0;
  end

  // Monitor: every consumed instruction must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && !redirect_valid && inst_valid && inst_ready) begin
        pop_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got pc=%h word=%h, required no instruction", inst_pc, inst);
        end else begin
          e = exp_q.pop_front();
          if (inst_pc !== e.pc || inst !== e.word) begin
            errors++;
            $display("FAIL pop_entry got pc=%h word=%h, required pc=%h word=%h",
                     inst_pc, inst, e.pc, e.word);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc   = pc;
    e.word = word;
    exp_q.push_back(e);
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Returns just after the edge at which a request is accepted; checks its address.
  task automatic wait_accept(input string name, input logic [63:0] exp_addr);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        ok = 1'b1;
        chk(name, imem_addr, exp_addr);
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no accepted request, required one within 60 cycles", name);
    end
    tick();
  endtask

  // Consume until the expected queue is empty, then stop consuming.
  task automatic drain(input string name);
    inst_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      tick();
    end
    inst_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got %0d pending, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b0;
    repeat (3) tick();

    // Reset state
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_inst_pc", inst_pc, 0);

    // Streaming from reset, one instruction every two cycles
    push_exp(64'h0, 32'hC0DE0000);
    push_exp(64'h4, 32'hC0DE0004);
    push_exp(64'h8, 32'hC0DE0008);
    pop_cyc.delete();
    tick();
    inst_ready = 1'b1;
    reset_n    = 1'b1;
    @(negedge clk);
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_addr, 64'h0);
    tick();
    drain("stream");
    if (pop_cyc.size() >= 3) begin
      chk("rate_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd2);
      chk("rate_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'd2);
    end else begin
      checks++;
      errors++;
      $display("FAIL rate_pops got %0d pops, required 3", pop_cyc.size());
    end

    // Backpressure: buffer fills to two entries and requests stop
    repeat (10) tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_valid", imem_req_valid, 0);
      chk("stall_inst_valid", inst_valid, 1);
    end
    chk("stall_head_pc", inst_pc, 64'hC);
    tick();
    imem_req_ready = 1'b0;
    push_exp(64'hC, 32'hC0DE000C);
    push_exp(64'h10, 32'hC0DE0010);
    drain("stall_drain");
    @(negedge clk);
    chk("stall_exactly_two", inst_valid, 0);
    chk("stall_next_addr", imem_addr, 64'h14);
    chk("stall_next_req", imem_req_valid, 1);
    tick();
    imem_req_ready = 1'b1;

    // Redirect while waiting, stale response three cycles later
    mem_delay = 3;
    wait_accept("wait_acc", 64'h14);
    redirect_to(64'h1003);
    @(negedge clk);
    chk("drain_req_off1", imem_req_valid, 0);
    tick();
    @(negedge clk);
    chk("drain_req_off2", imem_req_valid, 0);
    tick();
    @(negedge clk);
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_req_addr", imem_addr, 64'h1000);
    chk("redir_empty", inst_valid, 0);
    push_exp(64'h1000, 32'hC0DE1000);
    tick();
    drain("redir");

    // Redirect in the same cycle as the response
    mem_delay = 1;
    redirect_to(64'h1F00);
    wait_accept("coinc_acc", 64'h1F00);
    redirect_to(64'h2000);
    @(negedge clk);
    chk("coinc_empty", inst_valid, 0);
    chk("coinc_req_valid", imem_req_valid, 1);
    chk("coinc_req_addr", imem_addr, 64'h2000);
    push_exp(64'h2000, 32'hC0DE2000);
    tick();
    drain("coinc");

    // Address wrap at the top of the 64-bit space; low redirect bits ignored
    redirect_to(64'hFFFF_FFFF_FFFF_FFFF);
    push_exp(64'hFFFF_FFFF_FFFF_FFFC, 32'hC0DEFFFC);
    push_exp(64'h0, 32'hC0DE0000);
    wait_accept("wrap_first", 64'hFFFF_FFFF_FFFF_FFFC);
    wait_accept("wrap_next", 64'h0);
    drain("wrap");

    // Reset while a request is outstanding
    mem_delay = 3;
    redirect_to(64'h5000);
    wait_accept("mrst_acc", 64'h5000);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("mrst_inst_valid", inst_valid, 0);
    chk("mrst_inst", inst, 0);
    chk("mrst_inst_pc", inst_pc, 0);
    chk("mrst_req_valid", imem_req_valid, 1);
    chk("mrst_req_addr", imem_addr, 64'h0);
    push_exp(64'h0, 32'hC0DE0000);
    tick();
    drain("mrst");

    repeat (4) tick();
    chk("leftover_expected", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
